// File: rtl/color_pkg.sv
// Shared hue-wheel constants, sector encoding and the piecewise-linear
// sector-to-RGB mapping used by the hue sequencer.
package color_pkg;

   localparam int HUE_STEPS  = 360;
   localparam int SECTOR_LEN = 60;

   typedef enum logic [2:0] {
      SEC_0 = 3'd0,
      SEC_1 = 3'd1,
      SEC_2 = 3'd2,
      SEC_3 = 3'd3,
      SEC_4 = 3'd4,
      SEC_5 = 3'd5
   } sector_t;

   typedef struct packed {
      logic [15:0] r;
      logic [15:0] g;
      logic [15:0] b;
   } rgb_t;

   // Channel values for one sector; width <= 16, ramps never exceed MAX.
   function automatic rgb_t sector_rgb(input sector_t sector, input logic [5:0] offset,
                                       input int unsigned width);
      logic [15:0] max_s;
      logic [15:0] slope_s;
      logic [15:0] up_s;
      logic [15:0] down_s;
      rgb_t        rgb_s;
      max_s   = 16'((32'd1 << width) - 32'd1);
      slope_s = max_s / 16'(SECTOR_LEN);
      up_s    = 16'(offset) * slope_s;
      down_s  = max_s - up_s;
      case (sector)
         SEC_0:   rgb_s = '{r: max_s,  g: up_s,   b: 16'd0};
         SEC_1:   rgb_s = '{r: down_s, g: max_s,  b: 16'd0};
         SEC_2:   rgb_s = '{r: 16'd0,  g: max_s,  b: up_s};
         SEC_3:   rgb_s = '{r: 16'd0,  g: down_s, b: max_s};
         SEC_4:   rgb_s = '{r: up_s,   g: 16'd0,  b: max_s};
         SEC_5:   rgb_s = '{r: max_s,  g: 16'd0,  b: down_s};
         default: rgb_s = '{r: max_s,  g: 16'd0,  b: 16'd0};
      endcase
      return rgb_s;
   endfunction

endpackage

// File: rtl/hue_to_rgb.sv
// Two-stage hue-to-RGB pipeline: S1 splits hue into sector/offset,
// S2 registers the sector table result as the pending duty triple.
module hue_to_rgb
   import color_pkg::*;
#(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [8:0]       hue,
   output logic [WIDTH-1:0] pend_red,
   output logic [WIDTH-1:0] pend_green,
   output logic [WIDTH-1:0] pend_blue
);

   sector_t          sector_s;
   logic [5:0]       offset_s;
   sector_t          sector_r;
   logic [5:0]       offset_r;
   rgb_t             rgb_s;
   logic             rgb_unused_s;
   logic [WIDTH-1:0] pend_red_r;
   logic [WIDTH-1:0] pend_green_r;
   logic [WIDTH-1:0] pend_blue_r;

   // Sector = hue/60 and offset = hue mod 60 via a compare chain.
   always_comb begin
      sector_s = SEC_0;
      offset_s = 6'd0;
      if (hue < 9'd60) begin
         sector_s = SEC_0;
         offset_s = 6'(hue);
      end else if (hue < 9'd120) begin
         sector_s = SEC_1;
         offset_s = 6'(hue - 9'd60);
      end else if (hue < 9'd180) begin
         sector_s = SEC_2;
         offset_s = 6'(hue - 9'd120);
      end else if (hue < 9'd240) begin
         sector_s = SEC_3;
         offset_s = 6'(hue - 9'd180);
      end else if (hue < 9'd300) begin
         sector_s = SEC_4;
         offset_s = 6'(hue - 9'd240);
      end else begin
         sector_s = SEC_5;
         offset_s = 6'(hue - 9'd300);
      end
   end

   // S1 register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sector_r <= SEC_0;
         offset_r <= 6'd0;
      end else begin
         sector_r <= sector_s;
         offset_r <= offset_s;
      end
   end

   assign rgb_s        = sector_rgb(sector_r, offset_r, WIDTH);
   assign rgb_unused_s = ^rgb_s;

   // S2 register: pending triple; reset value matches hue 0 (MAX,0,0).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_red_r   <= {WIDTH{1'b1}};
         pend_green_r <= '0;
         pend_blue_r  <= '0;
      end else begin
         pend_red_r   <= rgb_s.r[WIDTH-1:0];
         pend_green_r <= rgb_s.g[WIDTH-1:0];
         pend_blue_r  <= rgb_s.b[WIDTH-1:0];
      end
   end

   assign pend_red   = pend_red_r;
   assign pend_green = pend_green_r;
   assign pend_blue  = pend_blue_r;

endmodule

// File: rtl/hue_sequencer.sv
// Colour-wheel source for the RGB PWM channels: prescaled hue counter,
// hue-to-RGB pipeline and period-aligned double-buffered duty outputs.
module hue_sequencer
   import color_pkg::*;
#(
   parameter int WIDTH      = 10,
   parameter int CLK_FREQ   = 12_000_000,
   parameter int STEPS      = 360,
   parameter int STEP_DELAY = CLK_FREQ / STEPS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             period_start,
   output logic [WIDTH-1:0] duty_r,
   output logic [WIDTH-1:0] duty_g,
   output logic [WIDTH-1:0] duty_b,
   output logic [8:0]       hue,
   output logic             step_tick,
   output logic             duty_upd
);

   localparam int            PW     = (STEP_DELAY > 2) ? $clog2(STEP_DELAY) : 1;
   localparam logic [PW-1:0] PRE_TC = PW'(STEP_DELAY - 1);

   logic [PW-1:0]    presc_r;
   logic [8:0]       hue_r;
   logic             tick_s;
   logic [WIDTH-1:0] pend_red_s;
   logic [WIDTH-1:0] pend_green_s;
   logic [WIDTH-1:0] pend_blue_s;
   logic [WIDTH-1:0] duty_r_r;
   logic [WIDTH-1:0] duty_g_r;
   logic [WIDTH-1:0] duty_b_r;
   logic             duty_upd_r;

   // A held prescaler at terminal count must not tick, hence the enable term.
   assign tick_s = enable && (presc_r == PRE_TC);

   // Prescaler and hue counter; both freeze while enable is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_r <= '0;
         hue_r   <= 9'd0;
      end else if (tick_s) begin
         presc_r <= '0;
         hue_r   <= (hue_r == 9'(STEPS - 1)) ? 9'd0 : hue_r + 9'd1;
      end else if (enable) begin
         presc_r <= presc_r + PW'(1);
      end else begin
         presc_r <= presc_r;
      end
   end

   hue_to_rgb #(
      .WIDTH(WIDTH)
   ) u_hue_to_rgb (
      .clk        (clk),
      .rst        (rst),
      .hue        (hue_r),
      .pend_red   (pend_red_s),
      .pend_green (pend_green_s),
      .pend_blue  (pend_blue_s)
   );

   // Shadow registers: duties only move on a PWM period boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_r_r   <= '0;
         duty_g_r   <= '0;
         duty_b_r   <= '0;
         duty_upd_r <= 1'b0;
      end else begin
         duty_upd_r <= period_start;
         if (period_start) begin
            duty_r_r <= pend_red_s;
            duty_g_r <= pend_green_s;
            duty_b_r <= pend_blue_s;
         end
      end
   end

   assign duty_r    = duty_r_r;
   assign duty_g    = duty_g_r;
   assign duty_b    = duty_b_r;
   assign duty_upd  = duty_upd_r;
   assign hue       = hue_r;
   assign step_tick = tick_s;

endmodule

// File: tb/tb_hue_sequencer.sv
// Self-checking bench for hue_sequencer: behavioural hue/duty model compared
// every cycle, plus directed colour-wheel, enable, coincidence and reset cases.
module tb_hue_sequencer;

   localparam int SD   = 4;
   localparam int MAXV = 1023;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       period_start = 1'b0;
   logic [9:0] duty_r, duty_g, duty_b;
   logic [8:0] hue;
   logic       step_tick, duty_upd;

   int n_tests = 0;
   int n_fail  = 0;
   bit check_en = 1'b0;

   hue_sequencer #(.WIDTH(10), .STEP_DELAY(SD)) dut (
      .clk(clk), .rst(rst), .enable(enable), .period_start(period_start),
      .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
      .hue(hue), .step_tick(step_tick), .duty_upd(duty_upd)
   );

   always #5 clk = ~clk;

   // Colour wheel straight from the hue angle.
   function automatic void hue_rgb(input int h, output int r, output int g, output int b);
      int up;
      up = (h % 60) * (MAXV / 60);
      case (h / 60)
         0: begin r = MAXV;      g = up;        b = 0;         end
         1: begin r = MAXV - up; g = MAXV;      b = 0;         end
         2: begin r = 0;         g = MAXV;      b = up;        end
         3: begin r = 0;         g = MAXV - up; b = MAXV;      end
         4: begin r = up;        g = 0;         b = MAXV;      end
         default: begin r = MAXV; g = 0;        b = MAXV - up; end
      endcase
   endfunction

   // Model: hue counter, 2-cycle delay line for pending, shadow load tracking.
   int m_presc = 0, m_hue = 0, m_s1 = 0, m_pend = 0, m_out_hue = 0;
   bit m_loaded = 1'b0, m_upd = 1'b0;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_presc <= 0; m_hue <= 0; m_s1 <= 0; m_pend <= 0;
         m_out_hue <= 0; m_loaded <= 1'b0; m_upd <= 1'b0;
      end else begin
         m_upd <= period_start;
         if (period_start) begin
            m_out_hue <= m_pend;
            m_loaded  <= 1'b1;
         end
         m_pend <= m_s1;
         m_s1   <= m_hue;
         if (enable) begin
            if (m_presc == SD - 1) begin
               m_presc <= 0;
               m_hue   <= (m_hue + 1) % 360;
            end else begin
               m_presc <= m_presc + 1;
            end
         end
      end
   end

   int er, eg, eb;
   bit etick;
   always @(negedge clk) begin
      if (check_en) begin
         if (m_loaded) hue_rgb(m_out_hue, er, eg, eb);
         else begin er = 0; eg = 0; eb = 0; end
         etick = enable && (m_presc == SD - 1);
         n_tests++;
         if (hue !== 9'(m_hue) || duty_r !== 10'(er) || duty_g !== 10'(eg) ||
             duty_b !== 10'(eb) || step_tick !== etick || duty_upd !== m_upd) begin
            n_fail++;
            $display("FAIL cycle_model t=%0t hue %0d/%0d rgb %0d,%0d,%0d / %0d,%0d,%0d tick %0b/%0b upd %0b/%0b",
                     $time, hue, m_hue, duty_r, duty_g, duty_b, er, eg, eb,
                     step_tick, etick, duty_upd, m_upd);
         end
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_hue(input int h, input int budget);
      int n;
      n = 0;
      while (int'(hue) != h && n < budget) begin
         cyc();
         n++;
      end
      chk($sformatf("wait_hue_%0d", h), int'(hue), h);
   endtask

   task automatic chk_rgb(input string name, input int r, input int g, input int b);
      chk({name, "_r"}, int'(duty_r), r);
      chk({name, "_g"}, int'(duty_g), g);
      chk({name, "_b"}, int'(duty_b), b);
   endtask

   // Wait for hue h, let pending settle, then pulse period_start once.
   task automatic load_at(input int h, input int r, input int g, input int b);
      wait_hue(h, 2000);
      cyc();
      cyc();
      period_start = 1'b1;
      cyc();
      period_start = 1'b0;
      chk_rgb($sformatf("load_h%0d", h), r, g, b);
      chk($sformatf("load_h%0d_upd", h), int'(duty_upd), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, g, b, h0, n;
      // Pin the model against hand-computed wheel points.
      hue_rgb(59, r, g, b);  chk("model_h59_g", g, 1003);
      hue_rgb(60, r, g, b);  chk("model_h60_r", r, 1023); chk("model_h60_g", g, 1023);
      hue_rgb(359, r, g, b); chk("model_h359_b", b, 20);
      hue_rgb(1, r, g, b);   chk("model_h1_g", g, 17);

      repeat (2) cyc();
      check_en = 1'b1;
      chk_rgb("in_reset", 0, 0, 0);

      // Release with enable high; period_start lands on the third edge.
      rst = 1'b0;
      enable = 1'b1;
      cyc();
      chk("rel_tick1", int'(step_tick), 0);
      cyc();
      chk_rgb("pre_pulse", 0, 0, 0);
      chk("rel_tick2", int'(step_tick), 0);
      period_start = 1'b1;
      cyc();
      period_start = 1'b0;
      chk_rgb("first_load", MAXV, 0, 0);
      chk("first_upd", int'(duty_upd), 1);
      chk("first_tick_cycle4", int'(step_tick), 1);
      cyc();
      chk("upd_once", int'(duty_upd), 0);
      chk("hue_after_tick", int'(hue), 1);

      load_at(59, 1023, 1003, 0);
      load_at(60, 1023, 1023, 0);
      load_at(359, 1023, 0, 20);
      wait_hue(0, 20);

      // period_start on the pending-update edge takes the old value.
      wait_hue(1, 20);
      cyc();
      period_start = 1'b1;
      cyc();
      chk_rgb("coincide_old", MAXV, 0, 0);
      cyc();
      period_start = 1'b0;
      chk_rgb("coincide_next", MAXV, 17, 0);
      chk("b2b_upd", int'(duty_upd), 1);

      // Freeze at terminal count.
      n = 0;
      while (step_tick !== 1'b1 && n < 20) begin cyc(); n++; end
      chk("find_tc", int'(step_tick), 1);
      enable = 1'b0;
      #1;
      h0 = int'(hue);
      chk("hold_no_tick", int'(step_tick), 0);
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("hold_tick", int'(step_tick), 0);
         chk("hold_hue", int'(hue), h0);
      end
      enable = 1'b1;
      #1;
      chk("reenable_tick", int'(step_tick), 1);
      cyc();
      chk("reenable_hue", int'(hue), (h0 + 1) % 360);

      // Randomised enable / period_start traffic against the model.
      for (int i = 0; i < 600; i++) begin
         enable = ($urandom_range(0, 7) != 0);
         period_start = ($urandom_range(0, 3) == 0);
         cyc();
      end
      enable = 1'b1;
      period_start = 1'b0;

      // Asynchronous reset mid-step at hue 200.
      wait_hue(200, 3000);
      period_start = 1'b1;
      cyc();
      period_start = 1'b0;
      cyc();
      #1;
      rst = 1'b1;
      #1;
      chk("async_hue", int'(hue), 0);
      chk_rgb("async_rgb", 0, 0, 0);
      cyc();
      rst = 1'b0;
      cyc();
      chk("rst_tick1", int'(step_tick), 0);
      cyc();
      chk("rst_tick2", int'(step_tick), 0);
      cyc();
      chk("rst_tick4", int'(step_tick), 1);
      chk("rst_hue0", int'(hue), 0);
      cyc();
      chk("rst_hue1", int'(hue), 1);

      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
